// File: rtl/xdisplay_pkg.sv
// Shared constants for the multiplexed 7-segment display: segment bit positions
// and the hex-to-segment table (active-high, bit 0 = segment a).
package xdisplay_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble + decimal point + blank to active-high 8-bit segment pattern.
module hex7seg_dec (
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    import xdisplay_pkg::*;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        seg = '0;
        if (!blank) begin
            seg[SEG_G:SEG_A] = HEX_SEG[nibble];
            seg[SEG_DP]      = dp;
        end
    end

endmodule

// File: rtl/xdisplay_mux.sv
// Time-multiplexed N-digit 7-segment driver: shadowed hex word, refresh prescaler,
// guard interval, blanking and leading-zero suppression, all outputs registered.
module xdisplay_mux #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 2,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] val_sel,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lz_suppress,
    output logic [7:0]            disp_value,
    output logic [N_DIGITS-1:0]   disp_sel,
    output logic                  digit_strobe
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(N_DIGITS);

    localparam logic [N_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? '1 : '0;
    localparam logic [7:0]          SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] val_q;
    logic [N_DIGITS-1:0]   dp_q;
    logic [N_DIGITS-1:0]   blank_q;

    logic [3:0]            nibbles [N_DIGITS];
    logic [N_DIGITS-1:0]   lz_mask;
    logic [N_DIGITS-1:0]   sel_onehot;
    logic [7:0]            seg_hi;
    logic                  lz_run;
    logic                  terminal;
    logic                  in_guard;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
        assign nibbles[g] = val_q[4*g +: 4];
    end

    assign terminal = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign in_guard = (cnt < CNT_W'(GUARD_CYCLES));

    // A digit is suppressed while it and every digit above it is a plain zero;
    // a set decimal point anywhere in that run stops the suppression.
    always_comb begin
        lz_mask = '0;
        // NOTE: lz_run is a scratch variable rippled through the loop, so it uses blocking '='.
        lz_run  = lz_suppress;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run & (nibbles[i] == 4'h0) & ~dp_q[i];
            lz_mask[i] = lz_run;
        end
    end

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[idx] = 1'b1;
    end

    hex7seg_dec u_dec (
        .nibble (nibbles[idx]),
        .dp     (dp_q[idx]),
        .blank  (blank_q[idx] | lz_mask[idx]),
        .seg    (seg_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= '0;
            val_q        <= '0;
            dp_q         <= '0;
            blank_q      <= '0;
            digit_strobe <= 1'b0;
            disp_sel     <= SEL_OFF;
            disp_value   <= SEG_OFF;
        end else begin
            // NOTE: all sequential state uses non-blocking '<=' so every register samples pre-edge values.
            digit_strobe <= enable & terminal;
            if (enable) begin
                if (terminal) begin
                    cnt <= '0;
                    idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (load) begin
                val_q   <= val_sel;
                dp_q    <= dp_in;
                blank_q <= blank_in;
            end

            if (!enable || in_guard) begin
                disp_sel   <= SEL_OFF;
                disp_value <= SEG_OFF;
            end else begin
                disp_sel   <= sel_onehot ^ SEL_OFF;
                disp_value <= seg_hi ^ SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_xdisplay_mux.sv
// Scoreboard bench for xdisplay_mux: a slot-position reference model predicts each
// registered output; a monitor pops and compares one prediction per clock.
module tb_xdisplay_mux;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int GUARD = 2;

    localparam logic [N-1:0] DARK_SEL = 4'hF;
    localparam logic [7:0]   DARK_SEG = 8'hFF;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [N-1:0] sel;
        logic [7:0]   value;
        logic         strobe;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic           load = 1'b0;
    logic [4*N-1:0] val_sel = '0;
    logic [N-1:0]   dp_in = '0;
    logic [N-1:0]   blank_in = '0;
    logic           lz_suppress = 1'b0;
    logic [7:0]     disp_value;
    logic [N-1:0]   disp_sel;
    logic           digit_strobe;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: absolute position in the scan frame plus shadows.
    int             m_pos = 0;
    logic [4*N-1:0] m_val = '0;
    logic [N-1:0]   m_dp = '0;
    logic [N-1:0]   m_blank = '0;

    always #5 clk = ~clk;

    xdisplay_mux #(
        .N_DIGITS       (N),
        .REFRESH_DIV    (DIV),
        .GUARD_CYCLES   (GUARD),
        .SEL_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .val_sel      (val_sel),
        .dp_in        (dp_in),
        .blank_in     (blank_in),
        .lz_suppress  (lz_suppress),
        .disp_value   (disp_value),
        .disp_sel     (disp_sel),
        .digit_strobe (digit_strobe)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    function automatic bit lz_dark(input int d);
        if (!lz_suppress || d == 0) return 1'b0;
        for (int j = d; j < N; j++)
            if (m_val[4*j +: 4] != 4'h0 || m_dp[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] model_seg(input int d);
        if (m_blank[d] || lz_dark(d)) return 8'h00;
        return {m_dp[d], SEG_TAB[m_val[4*d +: 4]]};
    endfunction

    // Predict the outputs of the coming clock edge from the current inputs and
    // model state, then advance the model and wait for the next drive point.
    task automatic tick();
        exp_t e;
        int   digit;
        int   phase;
        if (reset) begin
            e.sel = DARK_SEL; e.value = DARK_SEG; e.strobe = 1'b0;
            m_pos = 0; m_val = '0; m_dp = '0; m_blank = '0;
        end else begin
            digit    = m_pos / DIV;
            phase    = m_pos % DIV;
            e.strobe = enable && (phase == DIV - 1);
            if (!enable || phase < GUARD) begin
                e.sel = DARK_SEL; e.value = DARK_SEG;
            end else begin
                e.sel   = DARK_SEL ^ N'(1 << digit);
                e.value = ~model_seg(digit);
            end
            if (enable) m_pos = (m_pos + 1) % (N * DIV);
            if (load) begin
                m_val = val_sel; m_dp = dp_in; m_blank = blank_in;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] dp, input logic [N-1:0] bl);
        val_sel = v; dp_in = dp; blank_in = bl; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        run(cycles);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("disp_sel",     32'(disp_sel),     32'(e.sel));
                check("disp_value",   32'(disp_value),   32'(e.value));
                check("digit_strobe", 32'(digit_strobe), 32'(e.strobe));
            end
        end
    end

    initial begin : stimulus
        logic [4*N-1:0] v;
        @(negedge clk);

        // Reset held for three cycles.
        do_reset(3);

        // Scan order with 1234, two full frames.
        do_load(16'h1234, 4'b0000, 4'b0000);
        enable = 1'b1;
        run(2 * N * DIV);

        // Leading-zero suppression, then a dp that stops it on digit 2.
        enable = 1'b0;
        do_reset(1);
        lz_suppress = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        enable = 1'b1;
        run(N * DIV);
        do_load(16'h0050, 4'b0100, 4'b0000);
        run(N * DIV + 2);

        // Blank on digit 1, dp on digit 0.
        lz_suppress = 1'b0;
        do_load(16'hFFFF, 4'b0001, 4'b0010);
        run(N * DIV);

        // Freeze at idx=2, cnt=5 for ten cycles, then resume.
        do_reset(1);
        enable = 1'b1;
        run(2 * DIV + 5);
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(2 * DIV);

        // Load coincident with terminal count of digit 0.
        do_reset(1);
        run(DIV - 1);
        do_load(16'hABCD, 4'b0000, 4'b0000);
        run(2 * DIV);

        // Reset mid-slot, then running again.
        run(3);
        do_reset(1);
        run(DIV + 3);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 63) == 0) lz_suppress = ~lz_suppress;
            load = ($urandom_range(0, 11) == 0);
            for (int d = 0; d < N; d++)
                v[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            val_sel  = v;
            dp_in    = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            blank_in = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            tick();
        end
        reset = 1'b0; load = 1'b0;

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
